// File: rtl/nn_aarch_pkg.sv
// nn_aarch_pkg: shared widths, element type and loader state encoding for the MLP datapath
package nn_aarch_pkg;

    localparam int DATA_W = 8;
    localparam int IN_DIM = 16;
    localparam int IDX_W  = $clog2(IN_DIM);

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        WAIT,
        DRAIN
    } loader_state_e;

endpackage

// File: rtl/input_frame_loader_if.sv
// input_frame_loader_if: valid/ready element stream feeding the frame loader
interface input_frame_loader_if #(
    parameter int DATA_W = nn_aarch_pkg::DATA_W
);

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;

    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);

endinterface

// File: rtl/input_frame_loader.sv
// input_frame_loader: packs streamed elements into a flat vector, launches the network, rejects malformed frames
module input_frame_loader #(
    parameter int DATA_W = nn_aarch_pkg::DATA_W,
    parameter int IN_DIM = nn_aarch_pkg::IN_DIM,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input_frame_loader_if.slave      s,
    input  logic                     net_done,
    output logic [DATA_W*IN_DIM-1:0] bus_out,
    output logic                     start,
    output logic                     busy,
    output logic                     frame_err,
    output logic [CNT_W-1:0]         frame_count
);

    import nn_aarch_pkg::*;

    localparam int              IW       = $clog2(IN_DIM);
    localparam logic [IW-1:0]   LAST_IDX = IW'(IN_DIM - 1);

    loader_state_e             state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [DATA_W*IN_DIM-1:0]  bus_q, bus_d;
    logic                      err_q, err_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      beat, fill_beat, at_end;

    // state register and datapath flops, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            bus_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bus_q   <= bus_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: a frame completes only when s_last lands exactly on the final slot
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (beat && at_end) state_d = s.s_last ? LAUNCH : DRAIN;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (net_done) state_d = FILL;
            DRAIN:   if (beat && s.s_last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // state decode; s_ready is held low while reset is asserted
    always_comb begin
        s.s_ready = rst_n && (state_q == FILL || state_q == DRAIN);
        start     = state_q == LAUNCH;
        busy      = state_q == WAIT;
    end

    // packing, error pulse and launch counter; beats are stored only when they are not the offending one
    always_comb begin
        beat      = s.s_valid && s.s_ready;
        fill_beat = beat && state_q == FILL;
        at_end    = idx_q == LAST_IDX;
        idx_d     = (fill_beat && !s.s_last && !at_end) ? idx_q + 1'b1
                  : (fill_beat || state_q != FILL) ? '0 : idx_q;
        bus_d     = bus_q;
        if (fill_beat && s.s_last == at_end) bus_d[idx_q*DATA_W +: DATA_W] = s.s_data;
        err_d     = fill_beat && s.s_last != at_end;
        cnt_d     = cnt_q + CNT_W'(fill_beat && s.s_last && at_end);
    end

    assign bus_out     = bus_q;
    assign frame_err   = err_q;
    assign frame_count = cnt_q;

endmodule

// File: tb/tb_input_frame_loader.sv
// tb_input_frame_loader: directed and randomized frames checked cycle by cycle against a frame-level model
module tb_input_frame_loader;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            net_done = 1'b0;
    logic [DW*N-1:0] bus_out;
    logic            start, busy, frame_err;
    logic [CW-1:0]   frame_count;

    input_frame_loader_if #(.DATA_W(DW)) s_if ();

    input_frame_loader #(.DATA_W(DW), .IN_DIM(N), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (s_if.slave),
        .net_done    (net_done),
        .bus_out     (bus_out),
        .start       (start),
        .busy        (busy),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;

    // frame-level model: elements collected so far, whether a bad frame is being drained, and whether the network is running
    bit            m_rdy, m_start, m_busy, m_err, m_drop;
    int            m_idx;
    logic [DW*N-1:0] m_bus;
    int            m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rdy = 1; m_start = 0; m_busy = 0; m_err = 0; m_drop = 0;
        m_idx = 0; m_bus = '0; m_cnt = 0;
    endtask

    task automatic model(input bit v, input logic [DW-1:0] d, input bit l, input bit nd);
        bit n_rdy, n_start, n_busy, n_err;
        n_rdy = m_rdy; n_start = 0; n_busy = m_busy; n_err = 0;
        if (m_start) n_busy = 1;
        if (m_busy && nd) begin
            n_busy = 0;
            n_rdy = 1;
        end
        if (v && m_rdy) begin
            if (m_drop) begin
                if (l) m_drop = 0;
            end else if (m_idx == N - 1) begin
                if (l) begin
                    m_bus[m_idx*DW +: DW] = d;
                    n_start = 1;
                    n_rdy = 0;
                    m_cnt = (m_cnt + 1) % (1 << CW);
                end else begin
                    n_err = 1;
                    m_drop = 1;
                end
                m_idx = 0;
            end else if (l) begin
                n_err = 1;
                m_idx = 0;
            end else begin
                m_bus[m_idx*DW +: DW] = d;
                m_idx++;
            end
        end
        m_rdy = n_rdy; m_start = n_start; m_busy = n_busy; m_err = n_err;
    endtask

    task automatic compare_all();
        check("s_ready", 64'(s_if.s_ready), 64'(m_rdy));
        check("start", 64'(start), 64'(m_start));
        check("busy", 64'(busy), 64'(m_busy));
        check("frame_err", 64'(frame_err), 64'(m_err));
        check("bus_out", 64'(bus_out), 64'(m_bus));
        check("frame_count", 64'(frame_count), 64'(m_cnt));
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit nd);
        s_if.s_valid = v; s_if.s_data = d; s_if.s_last = l; net_done = nd;
        @(posedge clk);
        model(v, d, l, nd);
        @(negedge clk);
        compare_all();
        if (start) n_starts++;
    endtask

    task automatic send4(input logic [DW*N-1:0] w);
        for (int k = 0; k < N; k++) step(1, w[k*DW +: DW], k == N - 1, 0);
    endtask

    task automatic rearm();
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 1);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(s_if.s_ready), 64'd0);
        check("rst_bus", 64'(bus_out), 64'd0);
        check("rst_count", 64'(frame_count), 64'd0);
        check("rst_flags", {61'd0, start, busy, frame_err}, 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 64'(s_if.s_ready), 64'd1);
    endtask

    initial begin
        logic [DW*N-1:0] w;
        int s0;
        s_if.s_valid = 0; s_if.s_data = '0; s_if.s_last = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(s_if.s_ready), 64'd0);
        check("rst_bus", 64'(bus_out), 64'd0);
        check("rst_count", 64'(frame_count), 64'd0);
        check("rst_flags", {61'd0, start, busy, frame_err}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 64'(s_if.s_ready), 64'd1);

        send4(32'h44332211);
        check("nominal_start", 64'(start), 64'd1);
        check("nominal_bus", 64'(bus_out), 64'h44332211);
        check("nominal_count", 64'(frame_count), 64'd1);
        repeat (3) step(1, 8'h55, 0, 0);
        check("hold_bus", 64'(bus_out), 64'h44332211);
        step(1, 8'h66, 1, 1);
        check("rearm_ready", 64'(s_if.s_ready), 64'd1);
        send4(32'hA3A2A1A0);
        check("second_bus", 64'(bus_out), 64'hA3A2A1A0);
        rearm();

        step(1, 8'hD0, 0, 0);
        step(1, 8'hD1, 1, 0);
        check("short_err", 64'(frame_err), 64'd1);
        send4(32'h04030201);
        check("short_good_bus", 64'(bus_out), 64'h04030201);
        check("short_good_count", 64'(frame_count), 64'd3);
        rearm();

        for (int k = 0; k < 4; k++) step(1, 8'(8'hB0 + k), 0, 0);
        check("long_err", 64'(frame_err), 64'd1);
        step(1, 8'hB4, 0, 0);
        step(1, 8'hB5, 1, 0);
        send4(32'hC3C2C1C0);
        check("long_good_bus", 64'(bus_out), 64'hC3C2C1C0);
        check("long_good_count", 64'(frame_count), 64'd4);
        rearm();

        step(1, 8'hE0, 0, 0);
        step(1, 8'hE1, 0, 0);
        mid_reset();
        send4(32'hF3F2F1F0);
        check("fresh_bus", 64'(bus_out), 64'hF3F2F1F0);
        check("fresh_count", 64'(frame_count), 64'd1);
        rearm();

        mid_reset();
        s0 = n_starts;
        for (int f = 0; f < 17; f++) begin
            for (int k = 0; k < N; k++) begin
                repeat ($urandom_range(0, 2)) step(0, 8'($urandom), 1'($urandom), 0);
                w[k*DW +: DW] = 8'($urandom);
                step(1, w[k*DW +: DW], k == N - 1, 0);
            end
            check("rand_bus", 64'(bus_out), 64'(w));
            repeat (5) step(0, 8'($urandom), 0, 0);
            step(0, 8'h00, 0, 1);
        end
        check("rand_starts", 64'(n_starts - s0), 64'd17);
        check("wrap_count", 64'(frame_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
